// File: rtl/spu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spu_pkg                                                       |
// | Purpose  : Shared types for the SPU burst splitter: burst/len/size       |
// |            types, burst encodings, the beat record and a WRAP length     |
// |            legality helper.                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package spu_pkg;

  typedef logic [7:0] len_t;   // beats per burst minus one
  typedef logic [2:0] size_t;  // log2 of bytes per beat

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam int unsigned BEAT_ADDR_W_MAX = 64;
  localparam int unsigned BEAT_ID_W_MAX   = 16;

  // One emitted beat, sized for the widest supported configuration.
  typedef struct packed {
    logic [BEAT_ADDR_W_MAX-1:0] addr;
    len_t                       idx;
    logic                       last;
    logic [BEAT_ID_W_MAX-1:0]   id;
  } beat_rec_t;

  // A WRAP burst is only well formed for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input len_t len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spu_beat_addr_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spu_beat_addr_step                                            |
// | Purpose  : Combinational next-beat address generator.                    |
// |   cur_addr_i  : address of the beat being retired                        |
// |   size_i      : log2 bytes per beat                                      |
// |   len_i       : beats minus one (wrap region size)                       |
// |   burst_i     : effective burst type (RSVD never arrives here)           |
// |   boundary_i  : lower wrap boundary latched at acceptance                |
// |   next_addr_o : address of the following beat                            |
// | Config   : SPU_BURST_WRAP_EN adds the wrap comparison; without it the    |
// |            len/boundary inputs are ignored.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spu_beat_addr_step
  import spu_pkg::*;
#(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] cur_addr_i,
  input  size_t                size_i,
  input  len_t                 len_i,
  input  burst_t               burst_i,
  input  logic [AddrWidth-1:0] boundary_i,
  output logic [AddrWidth-1:0] next_addr_o
);

  logic [AddrWidth-1:0] w_step;
  logic [AddrWidth-1:0] w_aligned;
  logic [AddrWidth-1:0] w_incr;

  // Only the first beat may be unaligned; every later beat starts from the
  // aligned copy, so aligning the current address each step is harmless.
  assign w_step    = {{(AddrWidth-1){1'b0}}, 1'b1} << size_i;
  assign w_aligned = cur_addr_i & ~(w_step - {{(AddrWidth-1){1'b0}}, 1'b1});
  assign w_incr    = w_aligned + w_step;

`ifdef SPU_BURST_WRAP_EN
  localparam logic [AddrWidth-1:0] c_one = {{(AddrWidth-1){1'b0}}, 1'b1};

  logic [AddrWidth-1:0] w_wrap_bytes;
  logic [AddrWidth-1:0] w_wrap_end;

  assign w_wrap_bytes = ({{(AddrWidth-8){1'b0}}, len_i} + c_one) << size_i;
  // Steps are aligned multiples from inside the region, so the increment
  // lands exactly on the end address (including modulo roll-over).
  assign w_wrap_end   = boundary_i + w_wrap_bytes;

  always_comb begin
    next_addr_o = w_incr;
    case (burst_i)
      BURST_FIXED: next_addr_o = cur_addr_i;
      BURST_WRAP:  next_addr_o = (w_incr == w_wrap_end) ? boundary_i : w_incr;
      default:     next_addr_o = w_incr;
    endcase
  end
`else
  logic w_unused;
  assign w_unused = ^{len_i, boundary_i};

  always_comb begin
    next_addr_o = w_incr;
    case (burst_i)
      BURST_FIXED: next_addr_o = cur_addr_i;
      default:     next_addr_o = w_incr;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: rtl/spu_burst_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spu_burst_splitter                                            |
// | Purpose  : Splits an AXI-style burst request into individual beats.      |
// | Ports    :                                                               |
// |   clk_i, rst_ni         : clock, async active-low reset                  |
// |   req_valid_i/ready_o   : request handshake                              |
// |   req_addr/len/size/burst/id_i : request fields                          |
// |   beat_valid_o/ready_i  : beat handshake                                 |
// |   beat_addr/idx/last/id_o : current beat                                 |
// |   busy_o                : burst in progress                              |
// |   wrap_err_o            : single-cycle pulse when a request is accepted  |
// |                           with a reserved burst or an unusable WRAP      |
// | Config   : SPU_BURST_WRAP_EN enables wrapping bursts; when undefined     |
// |            every WRAP request is emitted as INCR and flagged.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spu_burst_splitter
  import spu_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  len_t                 req_len_i,
  input  size_t                req_size_i,
  input  burst_t               req_burst_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [7:0]           beat_idx_o,
  output logic                 beat_last_o,
  output logic [IdWidth-1:0]   beat_id_o,
  output logic                 busy_o,
  output logic                 wrap_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [AddrWidth-1:0] r_addr;
  len_t                 r_idx;
  len_t                 r_len;
  size_t                r_size;
  burst_t               r_burst;
  logic [IdWidth-1:0]   r_id;

  logic                 w_beat_hs;
  logic                 w_last;
  logic                 w_last_hs;
  logic                 w_accept;
  logic                 w_wrap_ok;
  logic                 w_req_err;
  burst_t               w_req_burst;
  logic [AddrWidth-1:0] w_next_addr;
  logic [AddrWidth-1:0] w_boundary;

  // ---------------------------------------------------------------------
  // Beat-side status
  // ---------------------------------------------------------------------
  assign beat_valid_o = (r_state == ST_BURST);
  assign w_beat_hs    = beat_valid_o && beat_ready_i;
  assign w_last       = beat_valid_o && (r_idx == r_len);
  assign w_last_hs    = w_beat_hs && w_last;

  assign beat_addr_o  = r_addr;
  assign beat_idx_o   = r_idx;
  assign beat_last_o  = w_last;
  assign beat_id_o    = r_id;

  // ---------------------------------------------------------------------
  // Request classification
  // ---------------------------------------------------------------------
`ifdef SPU_BURST_WRAP_EN
  localparam logic [AddrWidth-1:0] c_one = {{(AddrWidth-1){1'b0}}, 1'b1};

  logic [AddrWidth-1:0] w_wrap_bytes;
  logic [AddrWidth-1:0] w_boundary_in;
  logic [AddrWidth-1:0] r_boundary;

  assign w_wrap_ok     = (req_burst_i == BURST_WRAP) && wrap_len_legal(req_len_i);
  assign w_wrap_bytes  = ({{(AddrWidth-8){1'b0}}, req_len_i} + c_one) << req_size_i;
  assign w_boundary_in = req_addr_i & ~(w_wrap_bytes - c_one);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_boundary <= '0;
    end else if (w_accept) begin
      r_boundary <= w_boundary_in;
    end
  end

  assign w_boundary = r_boundary;
`else
  assign w_wrap_ok  = 1'b0;
  assign w_boundary = '0;
`endif

  // Unusable WRAP and the reserved code both degrade to INCR.
  assign w_req_err = (req_burst_i == BURST_RSVD) ||
                     ((req_burst_i == BURST_WRAP) && !w_wrap_ok);

  always_comb begin
    w_req_burst = BURST_INCR;
    if (req_burst_i == BURST_FIXED) begin
      w_req_burst = BURST_FIXED;
    end else if (w_wrap_ok) begin
      w_req_burst = BURST_WRAP;
    end
  end

  assign wrap_err_o = w_accept && w_req_err;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready is raised during the last-beat handshake so that a waiting
  // request is taken in the same cycle and its first beat follows directly.
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    busy_o      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        w_accept    = req_valid_i;
        if (req_valid_i) begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        busy_o = 1'b1;
        if (w_last_hs) begin
          req_ready_o = 1'b1;
          w_accept    = req_valid_i;
          w_state_nxt = req_valid_i ? ST_BURST : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Beat datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= BURST_FIXED;
      r_id    <= '0;
    end else if (w_accept) begin
      r_addr  <= req_addr_i;
      r_idx   <= '0;
      r_len   <= req_len_i;
      r_size  <= req_size_i;
      r_burst <= w_req_burst;
      r_id    <= req_id_i;
    end else if (w_beat_hs && !w_last) begin
      r_addr  <= w_next_addr;
      r_idx   <= r_idx + 8'd1;
    end
  end

  spu_beat_addr_step #(
    .AddrWidth (AddrWidth)
  ) u_addr_step (
    .cur_addr_i  (r_addr),
    .size_i      (r_size),
    .len_i       (r_len),
    .burst_i     (r_burst),
    .boundary_i  (w_boundary),
    .next_addr_o (w_next_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_spu_burst_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spu_burst_splitter                                         |
// | Purpose  : Scoreboard bench for spu_burst_splitter. Accepted requests    |
// |            are expanded by a reference model into expected beats; a      |
// |            monitor compares every presented beat against the queue.      |
// | Config   : follows SPU_BURST_WRAP_EN like the design.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_spu_burst_splitter;
  import spu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  burst_t      req_burst = BURST_FIXED;
  logic [3:0]  req_id = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic [63:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [3:0]  beat_id;
  logic        busy;
  logic        wrap_err;

  int          total = 0;
  int          bad = 0;
  beat_rec_t   exp_q[$];
  bit          mon_off = 1'b0;
  bit          chk_bubble = 1'b0;
  bit          rdy_random = 1'b0;

  spu_burst_splitter #(.AddrWidth(64), .IdWidth(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .req_size_i   (req_size),
    .req_burst_i  (req_burst),
    .req_id_i     (req_id),
    .beat_valid_o (beat_valid),
    .beat_ready_i (beat_ready),
    .beat_addr_o  (beat_addr),
    .beat_idx_o   (beat_idx),
    .beat_last_o  (beat_last),
    .beat_id_o    (beat_id),
    .busy_o       (busy),
    .wrap_err_o   (wrap_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: expands one request into its beats from the address
  // rules (start, aligned start + N*size, or wrap inside an aligned window).
  function automatic bit model_push(input longint unsigned a, input int len, input int size,
                                    input int burst, input int id);
    bit              wrap_use;
    bit              err;
    longint unsigned step, aligned, total_b, base, addr;
    beat_rec_t       rec;
`ifdef SPU_BURST_WRAP_EN
    wrap_use = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
`else
    wrap_use = 1'b0;
`endif
    err     = (burst == 3) || (burst == 2 && !wrap_use);
    step    = 64'd1 << size;
    aligned = a - (a % step);
    total_b = longint'(len + 1) * step;
    base    = a - (a % total_b);
    for (int n = 0; n <= len; n++) begin
      if (n == 0 || burst == 0)
        addr = a;
      else if (wrap_use)
        addr = base + ((aligned - base + longint'(n) * step) % total_b);
      else
        addr = aligned + longint'(n) * step;
      rec.addr = addr;
      rec.idx  = 8'(n);
      rec.last = (n == len);
      rec.id   = 16'(id);
      exp_q.push_back(rec);
    end
    return err;
  endfunction

  task automatic send(input logic [63:0] a, input int len, input int size,
                      input int burst, input int id);
    bit err;
    bit done;
    int cyc;
    req_addr  = a;
    req_len   = 8'(len);
    req_size  = 3'(size);
    req_burst = burst_t'(2'(burst));
    req_id    = 4'(id);
    req_valid = 1'b1;
    done = 1'b0;
    cyc  = 0;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        err  = model_push(a, len, size, burst, id);
        check("wrap_err_at_accept", {63'd0, wrap_err}, {63'd0, err});
      end else if (++cyc > 3000) begin
        done = 1'b1;
        total++;
        bad++;
        $display("FAIL req_accept_timeout: got no ready expected ready within 3000 cycles");
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Random backpressure driver
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_random) beat_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  initial forever begin
    beat_rec_t act;
    beat_rec_t exp;
    @(negedge clk);
    if (rst_ni && !mon_off) begin
      if (chk_bubble) begin
        check("no_bubble_valid", {63'd0, beat_valid}, 64'd1);
        chk_bubble = 1'b0;
      end
      if (!(req_valid && req_ready))
        check("wrap_err_quiet", {63'd0, wrap_err}, 64'd0);
      if (beat_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got addr %0h idx %0d expected no beat", beat_addr, beat_idx);
        end else begin
          exp      = exp_q[0];
          act.addr = beat_addr;
          act.idx  = beat_idx;
          act.last = beat_last;
          act.id   = {12'd0, beat_id};
          if (act !== exp) begin
            bad++;
            $display("FAIL beat: got addr=%0h idx=%0d last=%0b id=%0h expected addr=%0h idx=%0d last=%0b id=%0h",
                     act.addr, act.idx, act.last, act.id, exp.addr, exp.idx, exp.last, exp.id);
          end
          if (beat_ready) begin
            void'(exp_q.pop_front());
            if (beat_last && req_valid && req_ready) chk_bubble = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int len, burst;
    #2 rst_ni = 1'b0;
    @(negedge clk);
    check("rst_valid", {63'd0, beat_valid}, 64'd0);
    check("rst_last", {63'd0, beat_last}, 64'd0);
    check("rst_idx", {56'd0, beat_idx}, 64'd0);
    check("rst_addr", beat_addr, 64'd0);
    check("rst_id", {60'd0, beat_id}, 64'd0);
    check("rst_wrap_err", {63'd0, wrap_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Directed patterns, full throughput
    send(64'h1002, 2, 2, 1, 1); wait_drain();   // INCR unaligned
    send(64'h1038, 3, 3, 2, 2); wait_drain();   // WRAP len 3
    send(64'h2000, 2, 2, 0, 3); wait_drain();   // FIXED
    send(64'h3010, 2, 2, 2, 4); wait_drain();   // WRAP illegal len
    send(64'h3100, 1, 1, 3, 6); wait_drain();   // reserved burst
    send(64'hFFFF_FFFF_FFFF_FFF0, 3, 3, 1, 7); wait_drain(); // address roll-over
    send(64'h7000, 0, 0, 1, 8); wait_drain();   // single beat

    // Stall on beat 1 for 5 cycles, then a request waiting for the last beat
    beat_ready = 1'b0;
    send(64'h4000, 3, 3, 1, 5);
    @(posedge clk); #1 beat_ready = 1'b1;
    @(posedge clk); #1 beat_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 beat_ready = 1'b1;
    send(64'h6008, 3, 2, 2, 9);
    wait_drain();

    // Reset in the middle of a len 7 burst
    send(64'h5000, 7, 0, 1, 10);
    cyc = 0;
    while (!(beat_valid && beat_idx == 8'd2) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_beat2", {56'd0, beat_idx}, 64'd2);
    mon_off = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    exp_q.delete();
    chk_bubble = 1'b0;
    check("midrst_valid", {63'd0, beat_valid}, 64'd0);
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_idx", {56'd0, beat_idx}, 64'd0);
    check("midrst_addr", beat_addr, 64'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("postrst_no_beat", {63'd0, beat_valid}, 64'd0);
      check("postrst_ready", {63'd0, req_ready}, 64'd1);
    end
    mon_off = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    rdy_random = 1'b1;
    for (int r = 0; r < 60; r++) begin
      burst = int'($urandom_range(0, 3));
      len   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 15));
      if (burst == 2 && $urandom_range(0, 2) != 0) len = (1 << $urandom_range(1, 4)) - 1;
      send({$urandom, $urandom}, len, int'($urandom_range(0, 7)), burst, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    wait_drain();
    rdy_random = 1'b0;
    beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("final_idle_busy", {63'd0, busy}, 64'd0);
    check("final_idle_ready", {63'd0, req_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
